reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: round-robin between two requesters plus a
// zero-fill sequence that sweeps registers 0..NUM_REGS-1.
module reg_write_arbiter #(
  parameter int unsigned NUM_REGS          = 32,
  parameter bit          ZERO_REG_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [4:0]  req0_reg,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        RegWrite,
  output logic [4:0]  Write_Reg_Num_1,
  output logic [31:0] Write_Data,
  output logic        grant_id
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Last register of the sweep; reaching it forces the exit back to ARB.
  localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [REG_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              we_d;
  logic [REG_W-1:0]  addr_d;
  logic [DATA_W-1:0] data_d;
  logic              gid_d;
  logic              busy_d;

  // State, pointer, counter and registered write-port outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= ST_ARB;
      cnt_q           <= '0;
      rr_q            <= 1'b0;
      RegWrite        <= 1'b0;
      Write_Reg_Num_1 <= '0;
      Write_Data      <= '0;
      grant_id        <= 1'b0;
      clr_busy        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rr_q            <= rr_d;
      RegWrite        <= we_d;
      Write_Reg_Num_1 <= addr_d;
      Write_Data      <= data_d;
      grant_id        <= gid_d;
      clr_busy        <= busy_d;
    end
  end

  // Next-state, handshake and next write-port values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    we_d       = 1'b0;
    addr_d     = Write_Reg_Num_1;
    data_d     = Write_Data;
    gid_d      = 1'b0;
    busy_d     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          // Clear wins over same-cycle requests; register 0 goes out first.
          state_d = ST_CLEAR;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          busy_d  = 1'b1;
        end else begin
          req0_ready = req0_valid && (!req1_valid || !rr_q);
          req1_ready = req1_valid && (!req0_valid ||  rr_q);
          if (req0_valid && req1_valid) begin
            rr_d = ~rr_q;
          end
          if (req0_ready) begin
            if (ZERO_REG_WRITABLE || (req0_reg != '0)) begin
              we_d   = 1'b1;
              addr_d = req0_reg;
              data_d = req0_data;
              gid_d  = 1'b0;
            end
          end else if (req1_ready) begin
            if (ZERO_REG_WRITABLE || (req1_reg != '0)) begin
              we_d   = 1'b1;
              addr_d = req1_reg;
              data_d = req1_data;
              gid_d  = 1'b1;
            end
          end
        end
      end

      ST_CLEAR: begin
        // Issue the next register of the sweep; clr_start is ignored here.
        we_d   = 1'b1;
        addr_d = cnt_q + REG_W'(1);
        data_d = '0;
        busy_d = 1'b1;
        cnt_d  = cnt_q + REG_W'(1);
        if ((cnt_q + REG_W'(1)) == LAST_REG) begin
          state_d = ST_ARB;
        end
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a cycle-indexed reference model
// predicts handshakes and the writes expected on the register-file port.
module tb_reg_write_arbiter;

  localparam int NUM_REGS = 32;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg = '0, req1_reg = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        RegWrite;
  logic [4:0]  Write_Reg_Num_1;
  logic [31:0] Write_Data;
  logic        grant_id;

  reg_write_arbiter #(.NUM_REGS(NUM_REGS), .ZERO_REG_WRITABLE(1'b0)) dut (
    .clk(clk), .Reset(Reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_reg(req0_reg), .req1_reg(req1_reg),
    .req0_data(req0_data), .req1_data(req1_data),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .RegWrite(RegWrite), .Write_Reg_Num_1(Write_Reg_Num_1),
    .Write_Data(Write_Data), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          when;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gid;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_writes = 0;

  // Reference model state: round-robin bit and the cycle of the last clear start.
  logic m_rr = 1'b0;
  int   m_clr_t0 = -1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
      n_vec++; n_err++;
      $display("FAIL missing_write: got none expected addr %h data %h (cycle %0d)",
               exp_q[0].addr, exp_q[0].data, exp_q[0].when);
      void'(exp_q.pop_front());
    end
    if (RegWrite === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0 || exp_q[0].when != cyc) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write (cycle %0d)",
                 Write_Reg_Num_1, Write_Data, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(Write_Reg_Num_1), 32'(e.addr));
        chk("wr_data", Write_Data, e.data);
        chk("wr_gid", 32'(grant_id), 32'(e.gid));
      end
    end
  end

  // One cycle of stimulus: drive, predict handshake from the rules, push writes.
  task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic cs, output logic a0, output logic a1);
    int  c;
    logic in_clear, busy_exp, e0, e1;
    @(negedge clk);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    clr_start  = cs;
    #1;
    c        = cyc;
    in_clear = (c > m_clr_t0) && (c < m_clr_t0 + NUM_REGS);
    busy_exp = (c > m_clr_t0) && (c <= m_clr_t0 + NUM_REGS);
    chk("clr_busy", 32'(clr_busy), 32'(busy_exp));
    e0 = 1'b0; e1 = 1'b0;
    if (!in_clear && !cs) begin
      if (v0 && v1) begin
        e0 = ~m_rr; e1 = m_rr; m_rr = ~m_rr;
      end else begin
        e0 = v0; e1 = v1;
      end
    end
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    if (!in_clear && cs) begin
      m_clr_t0 = c;
      for (int k = 0; k < NUM_REGS; k++) exp_q.push_back('{c + 1 + k, 5'(k), 32'h0, 1'b0});
    end
    if (e0 && r0 != 5'd0) exp_q.push_back('{c + 1, r0, d0, 1'b0});
    if (e1 && r1 != 5'd0) exp_q.push_back('{c + 1, r1, d1, 1'b1});
    a0 = e0; a1 = e1;
  endtask

  task automatic idle(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_we"}, 32'(RegWrite), 32'h0);
    chk({tag, "_addr"}, 32'(Write_Reg_Num_1), 32'h0);
    chk({tag, "_data"}, Write_Data, 32'h0);
    chk({tag, "_gid"}, 32'(grant_id), 32'h0);
    chk({tag, "_busy"}, 32'(clr_busy), 32'h0);
  endtask

  // Asynchronous reset mid-cycle; model forgets every pending write.
  task automatic do_reset();
    @(negedge clk);
    #2;
    req0_valid = 0; req1_valid = 0; clr_start = 0;
    Reset = 1'b0;
    #1;
    check_zero_outputs("rst");
    exp_q.delete();
    m_rr = 1'b0;
    m_clr_t0 = -1000;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
  endtask

  initial begin
    logic a0, a1;
    int   i0, i1, guard, w0;
    logic p0v, p1v;
    logic [4:0]  p0r, p1r;
    logic [31:0] p0d, p1d;

    // Initial reset state
    #2;
    check_zero_outputs("init");
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;

    // Single requester write
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, a0, a1);
    idle(2);

    // Both valid: alternating grants, each side holds until accepted
    i0 = 0; i1 = 0; guard = 0;
    while ((i0 < 4 || i1 < 4) && guard < 20) begin
      step(i0 < 4, 5'(1 + i0), 32'h1000 + 32'(i0), i1 < 4, 5'(9 + i1), 32'h2000 + 32'(i1), 0, a0, a1);
      if (a0) i0++;
      if (a1) i1++;
      guard++;
    end
    chk("rr_drain_done", 32'(i0 + i1), 32'd8);
    idle(2);

    // Write to register 0 is accepted but never issued
    step(0, 0, 0, 1, 5'd0, 32'h12345678, 0, a0, a1);
    idle(1);
    chk("zero_reg_we", 32'(RegWrite), 32'h0);

    // Clear with a same-cycle request; request goes out after the sweep
    w0 = n_writes;
    step(1, 5'd7, 32'hCAFE0007, 0, 0, 0, 1, a0, a1);
    guard = 0;
    while (!a0 && guard < 60) begin
      step(1, 5'd7, 32'hCAFE0007, 0, 0, 0, 0, a0, a1);
      guard++;
    end
    chk("clr_req_accepted", 32'(a0), 32'h1);
    idle(3);
    chk("clr_write_count", 32'(n_writes - w0), 32'd33);

    // Re-pulse during clear at write 5 is ignored
    w0 = n_writes;
    step(0, 0, 0, 0, 0, 0, 1, a0, a1);
    idle(5);
    step(0, 0, 0, 0, 0, 0, 1, a0, a1);
    idle(40);
    chk("reclr_write_count", 32'(n_writes - w0), 32'd32);

    // Reset while clear write 10 is on the port
    step(0, 0, 0, 0, 0, 0, 1, a0, a1);
    idle(10);
    do_reset();
    w0 = n_writes;
    idle(40);
    chk("post_rst_writes", 32'(n_writes - w0), 32'd0);
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, a0, a1);
    chk("post_rst_rr", 32'(a0), 32'h1);
    step(0, 0, 0, 1, 5'd4, 32'h44, 0, a0, a1);
    idle(2);

    // Randomized traffic with occasional clears
    p0v = 0; p1v = 0; p0r = 0; p1r = 0; p0d = 0; p1d = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!p0v && $urandom_range(0, 3) != 0) begin
        p0v = 1; p0r = 5'($urandom_range(0, 31)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 3) != 0) begin
        p1v = 1; p1r = 5'($urandom_range(0, 31)); p1d = $urandom;
      end
      step(p0v, p0r, p0d, p1v, p1r, p1d, $urandom_range(0, 60) == 0, a0, a1);
      if (a0) p0v = 0;
      if (a1) p1v = 0;
    end

    idle(NUM_REGS + 4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
